// File: rtl/game_end_pkg.sv
// Shared types and helpers for the end-of-game monitor.
// Cause selection is fixed priority: the lowest set index wins.
package game_end_pkg;

    typedef enum logic [2:0] {IDLE, PLAY, GRACE, ENDING, OVER} end_state_t;

    function automatic int lowestSet(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/game_end_monitor_if.sv
// Condition/status bundle between the collision logic (master) and the
// end-of-game monitor (slave).
interface game_end_monitor_if #(
    parameter int N_COND = 3,
    parameter int LIVES  = 3
);
    localparam int CW = (N_COND > 1) ? $clog2(N_COND) : 1;
    localparam int LW = $clog2(LIVES + 1);

    logic              start;
    logic [N_COND-1:0] cond;
    logic              playing;
    logic              invulnerable;
    logic              ending;
    logic              end_game;
    logic              end_pulse;
    logic [CW-1:0]     end_cause;
    logic [LW-1:0]     lives_left;

    modport master (
        output start, cond,
        input  playing, invulnerable, ending, end_game, end_pulse, end_cause, lives_left
    );

    modport slave (
        input  start, cond,
        output playing, invulnerable, ending, end_game, end_pulse, end_cause, lives_left
    );

endinterface

// File: rtl/game_end_monitor_timer.sv
// Loadable saturating down-counter; one instance serves both the grace
// window and the ending dwell since those phases never overlap.
module game_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= loadValue;
        else if (en && count != '0)
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/game_end_monitor.sv
// Registered end-of-game monitor: lives/grace handling, cause latch,
// ENDING dwell and OVER hold until the next start.
module game_end_monitor
    import game_end_pkg::*;
#(
    parameter int                N_COND       = 3,
    parameter logic [N_COND-1:0] LIFE_MASK    = N_COND'(1),
    parameter int                LIVES        = 3,
    parameter int                GRACE_CYCLES = 16,
    parameter int                END_DELAY    = 4
) (
    input  logic            clk,
    input  logic            reset,
    game_end_monitor_if.slave bus
);
    localparam int CW   = (N_COND > 1) ? $clog2(N_COND) : 1;
    localparam int LW   = $clog2(LIVES + 1);
    localparam int TMAX = (GRACE_CYCLES > END_DELAY) ? GRACE_CYCLES : END_DELAY;
    localparam int TW   = $clog2(TMAX + 1);

    end_state_t        state, stateNext;
    logic [LW-1:0]     lives, livesNext;
    logic [CW-1:0]     cause, causeNext;
    logic              pulse;
    logic              tmrLoad, tmrEn, tmrZero;
    logic [TW-1:0]     tmrLoadVal;
    logic [N_COND-1:0] fatalVec, lifeVec;

    assign fatalVec = bus.cond & ~LIFE_MASK;
    assign lifeVec  = bus.cond & LIFE_MASK;

    game_timer #(.W(TW)) uTimer (
        .clk       (clk),
        .reset     (reset),
        .load      (tmrLoad),
        .loadValue (tmrLoadVal),
        .en        (tmrEn),
        .zero      (tmrZero)
    );

    always_comb begin
        stateNext  = state;
        livesNext  = lives;
        causeNext  = cause;
        tmrLoad    = 1'b0;
        tmrLoadVal = '0;
        tmrEn      = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (bus.start) begin
                    stateNext = PLAY;
                    livesNext = LW'(LIVES);
                    causeNext = '0;
                end
            end
            PLAY: begin
                if (fatalVec != '0) begin
                    stateNext  = ENDING;
                    causeNext  = CW'(lowestSet(32'(fatalVec)));
                    tmrLoad    = 1'b1;
                    tmrLoadVal = TW'(END_DELAY - 1);
                end else if (lifeVec != '0 && lives <= LW'(1)) begin
                    // Last life: go straight to the end sequence instead of wrapping.
                    stateNext  = ENDING;
                    livesNext  = '0;
                    causeNext  = CW'(lowestSet(32'(lifeVec)));
                    tmrLoad    = 1'b1;
                    tmrLoadVal = TW'(END_DELAY - 1);
                end else if (lifeVec != '0) begin
                    stateNext  = GRACE;
                    livesNext  = lives - LW'(1);
                    tmrLoad    = 1'b1;
                    tmrLoadVal = TW'(GRACE_CYCLES - 1);
                end
            end
            GRACE: begin
                if (fatalVec != '0) begin
                    stateNext  = ENDING;
                    causeNext  = CW'(lowestSet(32'(fatalVec)));
                    tmrLoad    = 1'b1;
                    tmrLoadVal = TW'(END_DELAY - 1);
                end else if (tmrZero) begin
                    stateNext = PLAY;
                end else begin
                    tmrEn = 1'b1;
                end
            end
            ENDING: begin
                if (tmrZero) stateNext = OVER;
                else         tmrEn     = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lives <= LW'(LIVES);
            cause <= '0;
            pulse <= 1'b0;
        end else begin
            state <= stateNext;
            lives <= livesNext;
            cause <= causeNext;
            // Strobe only on the ENDING->OVER edge; a held start cannot suppress it.
            pulse <= (state == ENDING) && (stateNext == OVER);
        end
    end

    assign bus.playing      = (state == PLAY) || (state == GRACE);
    assign bus.invulnerable = (state == GRACE);
    assign bus.ending       = (state == ENDING);
    assign bus.end_game     = (state == OVER);
    assign bus.end_pulse    = pulse;
    assign bus.end_cause    = cause;
    assign bus.lives_left   = lives;

endmodule

// File: tb/tb_game_end_monitor.sv
// Directed plan sequences plus random traffic, every cycle compared
// against a phase/countdown model of the game rules.
module tb_game_end_monitor;
    localparam int               N_COND = 3;
    localparam logic [2:0]       MASK   = 3'b001;
    localparam int               LIVES  = 3;
    localparam int               GRACE  = 16;
    localparam int               DELAY  = 4;

    localparam int M_IDLE = 0, M_RUN = 1, M_DYING = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // model state
    int mode, mLives, mCause, graceLeft, endLeft;
    bit mPulse;

    game_end_monitor_if #(.N_COND(N_COND), .LIVES(LIVES)) bus ();

    game_end_monitor #(
        .N_COND(N_COND), .LIFE_MASK(MASK), .LIVES(LIVES),
        .GRACE_CYCLES(GRACE), .END_DELAY(DELAY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [2:0] v);
        for (int i = 0; i < 3; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic void modelStep(input bit r, input bit s, input logic [2:0] c);
        logic [2:0] fatal, hit;
        fatal  = c & ~MASK;
        hit    = c & MASK;
        mPulse = 1'b0;
        if (r) begin
            mode = M_IDLE; mLives = LIVES; mCause = 0; graceLeft = 0; endLeft = 0;
            return;
        end
        case (mode)
            M_IDLE, M_DONE: if (s) begin
                mode = M_RUN; mLives = LIVES; mCause = 0; graceLeft = 0;
            end
            M_RUN: begin
                if (fatal != 0) begin
                    mode = M_DYING; endLeft = DELAY; mCause = lowest(fatal); graceLeft = 0;
                end else if (graceLeft > 0) begin
                    graceLeft--;
                end else if (hit != 0) begin
                    if (mLives == 1) begin
                        mode = M_DYING; endLeft = DELAY; mLives = 0; mCause = lowest(hit);
                    end else begin
                        mLives--; graceLeft = GRACE;
                    end
                end
            end
            default: begin
                endLeft--;
                if (endLeft == 0) begin
                    mode = M_DONE; mPulse = 1'b1;
                end
            end
        endcase
    endfunction

    task automatic compareAll();
        chk("playing",      bus.playing,      mode == M_RUN);
        chk("invulnerable", bus.invulnerable, (mode == M_RUN) && (graceLeft > 0));
        chk("ending",       bus.ending,       mode == M_DYING);
        chk("end_game",     bus.end_game,     mode == M_DONE);
        chk("end_pulse",    bus.end_pulse,    mPulse);
        chk("end_cause",    bus.end_cause,    mCause);
        chk("lives_left",   bus.lives_left,   mLives);
    endtask

    task automatic tick(input bit r, input bit s, input logic [2:0] c);
        reset     = r;
        bus.start = s;
        bus.cond  = c;
        @(posedge clk);
        modelStep(r, s, c);
        #1;
        compareAll();
    endtask

    task automatic idle(input int n, input logic [2:0] c);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, c);
    endtask

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.cond = '0;
        mode = M_IDLE; mLives = LIVES; mCause = 0; graceLeft = 0; endLeft = 0; mPulse = 0;

        // reset state, fatal end with cause 1
        tick(1, 0, 3'b000); tick(1, 0, 3'b111);
        tick(0, 1, 3'b000); tick(0, 0, 3'b010); idle(7, 3'b000);

        // life hit, grace, held hit costs another life after grace
        tick(0, 1, 3'b000); tick(0, 0, 3'b001); idle(20, 3'b000);
        idle(18, 3'b001); idle(3, 3'b000);

        // three separated hits run out of lives
        tick(0, 1, 3'b000);
        for (int k = 0; k < 3; k++) begin tick(0, 0, 3'b001); idle(18, 3'b000); end

        // fatal beats life, then 110
        tick(0, 1, 3'b000); tick(0, 0, 3'b111); idle(6, 3'b000);
        tick(0, 1, 3'b000); tick(0, 0, 3'b110); idle(6, 3'b000);

        // fatal during grace
        tick(0, 1, 3'b000); tick(0, 0, 3'b001); idle(3, 3'b000);
        tick(0, 0, 3'b100); idle(6, 3'b000);

        // reset mid-ENDING, then normal end and restart from OVER
        tick(0, 1, 3'b000); tick(0, 0, 3'b010); tick(0, 0, 3'b000);
        tick(1, 0, 3'b000); idle(2, 3'b000);
        tick(0, 1, 3'b000); tick(0, 0, 3'b100); idle(6, 3'b000);
        tick(0, 1, 3'b000); idle(2, 3'b000);

        // start held while entering OVER
        tick(0, 0, 3'b010); idle(3, 3'b000); tick(0, 1, 3'b000); tick(0, 1, 3'b000);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            bit         r, s;
            logic [2:0] c;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            tick(r, s, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_end_monitor.md
Name: game_end_monitor

Overview:
- Registered successor to the combinational end-of-game OR.
- Accepts a parametrised vector of end conditions. Life-consuming conditions (e.g. collision) decrement a lives counter and open an invulnerability grace window; fatal conditions end the game outright.
- Latches the winning cause, holds an ENDING dwell for the end animation, then asserts end_game until the next start.
- Sits between the game-object/collision logic and the display/score controller.

Parameters:
- N_COND, 3: number of end-condition inputs; must be ≥ 1.
- LIFE_MASK, 3'b001: per-bit mask; bit i = 1 means cond[i] consumes a life, bit i = 0 means cond[i] is fatal.
- LIVES, 3: lives loaded on start; must be ≥ 1.
- GRACE_CYCLES, 16: length of the invulnerability window after a life is lost; must be ≥ 1.
- END_DELAY, 4: number of cycles spent in ENDING before OVER; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; begins or restarts play from IDLE or OVER.
- cond  in  N_COND  end-condition levels, sampled every clk.
- playing  out  1  high in PLAY and GRACE.
- invulnerable  out  1  high in GRACE.
- ending  out  1  high in ENDING.
- end_game  out  1  high in OVER.
- end_pulse  out  1  one-cycle strobe on entry to OVER.
- end_cause  out  CW  index of the latched cause; CW = max(1, $clog2(N_COND)).
- lives_left  out  LW  remaining lives; LW = $clog2(LIVES+1).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values: state = IDLE; all flag outputs 0; end_cause = 0; lives_left = LIVES; timer = 0.
- All outputs are registered or decoded directly from registered state. There is no combinational path from cond to any output.
- Condition classification per cycle:
  - fatal = cond & ~LIFE_MASK
  - lifehit = |(cond & LIFE_MASK)
  - Cause selection uses fixed priority: lowest set index wins.
- IDLE:
  - start → PLAY; lives_left = LIVES; end_cause = 0.
  - cond is ignored.
- PLAY (transitions in priority order):
  - fatal ≠ 0 → ENDING; end_cause = lowest set index of fatal; lives_left unchanged.
  - Else lifehit with lives_left == 1 → ENDING; lives_left = 0; end_cause = lowest set index of cond & LIFE_MASK.
  - Else lifehit → GRACE; lives_left decremented by 1; timer = GRACE_CYCLES - 1.
  - start is ignored.
- GRACE:
  - Life conditions are ignored entirely.
  - A fatal condition → ENDING, same rule as in PLAY.
  - Otherwise timer decrements; timer == 0 → PLAY.
  - GRACE therefore lasts exactly GRACE_CYCLES cycles.
- ENDING:
  - Entry loads timer = END_DELAY - 1.
  - Decrements each cycle; timer == 0 → OVER. ENDING lasts exactly END_DELAY cycles.
  - cond and start are ignored.
- OVER:
  - end_game = 1 and end_pulse = 1 for the first OVER cycle only.
  - end_cause and lives_left hold.
  - start → PLAY with reload as from IDLE.
  - If start is held high while entering OVER, the restart occurs on the next edge. OVER lasts a minimum of 1 cycle, so end_pulse is always seen.
- Latency: a fatal cond sampled at edge k gives ending = 1 after edge k, and end_game = 1 after edge k + END_DELAY.
- A condition held high in PLAY is level-sensitive. A lifehit still present when GRACE expires costs another life on the first PLAY cycle.
- reset overrides everything in any state, including mid-ENDING and mid-GRACE.
- Decrementing lives_left never wraps below 0; the ENDING branch takes precedence when lives_left == 1.

Decomposition:
- Package game_end_pkg holds:
  - typedef enum logic [2:0] {IDLE, PLAY, GRACE, ENDING, OVER} end_state_t
  - a function that returns the lowest-set-bit index of a vector, used for cause selection.
- Sub-module game_timer: loadable down-counter with load, load_value, en and zero outputs. It is shared between GRACE and ENDING, since the two are mutually exclusive.

Test Plan (defaults: N_COND = 3, LIFE_MASK = 001, LIVES = 3, GRACE_CYCLES = 16, END_DELAY = 4):
1. Reset, then start for 1 cycle, then cond = 010 for 1 cycle → ending high next cycle; end_game high exactly 4 cycles later; end_pulse a single cycle; end_cause = 1; lives_left = 3.
2. In PLAY, cond = 001 pulse → lives_left = 2, invulnerable high for exactly 16 cycles. Then hold cond = 001 through GRACE → no further decrement until the first PLAY cycle, then lives_left = 1.
3. Three separated cond = 001 hits → lives_left steps 3 → 2 → 1 → 0; the third hit goes straight to ENDING; end_cause = 0; end_game after 4 cycles.
4. Simultaneous cond = 111 in PLAY → end_cause = 1 (fatal beats life); lives_left stays 3. Also cond = 110 → end_cause = 1.
5. cond = 100 during GRACE → ENDING entered on the next edge; end_cause = 2; invulnerable drops.
6. Assert reset during ENDING (timer = 2) → next cycle all outputs at reset values, state IDLE. Then start in OVER after a normal end → playing = 1, lives_left = 3, end_game = 0, end_cause = 0.
